sfifo_n_cache: RTL and testbench
================================

# sfifo_n_cache

Clocked, parametrised successor to the two-stage cache handshake FIFO. Buffers up to DEPTH words of WIDTH bits between a cache-side producer and consumer. Keeps the drive/free handshake naming and adds a data path, per-slot fire pulses, occupancy count, almost-full, synchronous flush and a sticky overflow flag. Sits between the cache request pipeline and the downstream memory-side stage.

## Interface
- DEPTH, 4: number of storage slots; legal range 2..64, need not be a power of two.
- WIDTH, 32: data width in bits; legal range 1..512.
- AFULL_TH, 3: o_afull asserts when count >= AFULL_TH; legal range 1..DEPTH.

- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_drive  input  1  producer push request, qualified by o_free in the same cycle.
- i_data  input  WIDTH  push data, sampled on an accepted push.
- o_free  output  1  space available (count < DEPTH).
- o_driveNext  output  1  head valid (count > 0).
- o_data  output  WIDTH  head word; valid only while o_driveNext = 1.
- i_freeNext  input  1  consumer accept; a pop occurs when o_driveNext && i_freeNext.
- i_flush  input  1  synchronous flush request.
- o_fire_N  output  DEPTH  one-cycle pulse on bit k when slot k is written.
- o_count  output  $clog2(DEPTH+1)  current occupancy.
- o_afull  output  1  count >= AFULL_TH.
- o_err  output  1  sticky overflow: set when i_drive = 1 while o_free = 0.

## Operation
- State: storage array mem[DEPTH], write pointer wptr, read pointer rptr (each $clog2(DEPTH) bits), count register, fire register, err register.
- push = i_drive && o_free && !i_flush; pop = o_driveNext && i_freeNext && !i_flush.
- On push: mem[wptr] <= i_data; fire <= one-hot(wptr); wptr advances. Otherwise fire <= 0.
- On pop: rptr advances.
- Pointer wrap: value DEPTH-1 advances to 0. No power-of-two arithmetic.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full (count = DEPTH): o_free = 0. A push is refused even when a pop occurs in the same cycle; there is no full-bypass. The refused i_drive sets o_err.
- Empty (count = 0): o_driveNext = 0 and i_freeNext is ignored. There is no empty fall-through: a pushed word appears on o_data the next cycle.
- o_data = mem[rptr], a combinational read of registered storage.
- Flush takes priority over push and pop. Next cycle: wptr = rptr = count = 0, fire = 0, err = 0. mem contents are not cleared. An i_drive in the flush cycle is dropped and does not set o_err.
- o_free, o_driveNext and o_afull are decoded combinationally from the count register only. They never depend combinationally on i_drive or i_freeNext.

## Timing
- Reset values (asynchronous, immediate on rst):
  - o_free = 1, o_driveNext = 0, o_data = 0 (mem reset to 0), o_fire_N = 0, o_count = 0, o_afull = 0, o_err = 0.
- Reset mid-operation discards all contents with no partial pop.
- After rst deasserts, the first push is accepted on the first clk edge.
- Push-to-head latency: 1 cycle when empty. Otherwise the word appears after all older words are popped.
- Pop: o_data and o_driveNext update on the edge after the pop cycle.
- o_fire_N pulses for exactly 1 cycle, in the cycle after the accepted push, and always has at most one bit set.
- Throughput: one push and one pop per cycle when 0 < count < DEPTH.
- o_err holds until rst or i_flush.

## Test plan
- Reset, then DEPTH=4: push A1..A4 on consecutive cycles.
  - o_fire_N = 0001, 0010, 0100, 1000 in successive cycles.
  - o_count reaches 4; o_free = 0; o_afull asserts at count 3.
  - A fifth i_drive sets o_err = 1 and count stays 4.
- Full plus simultaneous i_drive and i_freeNext: pop of A1 occurs, push is refused, count = 3, o_err = 1.
- Wrap-around with DEPTH=3:
  - Push 7 words with i_freeNext held at 1.
  - Pops return the words in order, with pointers wrapping 2 -> 0.
  - o_fire_N bit sequence is 0, 1, 2, 0, 1, 2, 0.
- Steady-state streaming at count = 2: push and pop each cycle for 10 cycles; count stays 2 and the data order is preserved.
- Flush with count = 3 and i_drive = 1 in the same cycle: next cycle count = 0, o_driveNext = 0, o_err = 0, and the dropped word never appears.
- Reset asserted asynchronously mid-cycle with count = 2: all outputs take their reset values immediately, with no clk edge required.

Source files
------------

// File: rtl/sfifo_n_cache_if.sv
// Handshake/data bundle for sfifo_n_cache.
//   Producer side : i_drive, i_data (push), o_free (space available)
//   Consumer side : o_driveNext, o_data (head), i_freeNext (accept)
//   Control       : i_flush
//   Status        : o_fire_N (per-slot write pulse), o_count, o_afull, o_err
// master modport is the cache-side user of the FIFO; slave modport is the FIFO.
interface sfifo_n_cache_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             i_drive;
  logic [WIDTH-1:0] i_data;
  logic             o_free;
  logic             o_driveNext;
  logic [WIDTH-1:0] o_data;
  logic             i_freeNext;
  logic             i_flush;
  logic [DEPTH-1:0] o_fire_N;
  logic [CW-1:0]    o_count;
  logic             o_afull;
  logic             o_err;

  modport master (
    output i_drive, i_data, i_freeNext, i_flush,
    input  o_free, o_driveNext, o_data, o_fire_N, o_count, o_afull, o_err
  );

  modport slave (
    input  i_drive, i_data, i_freeNext, i_flush,
    output o_free, o_driveNext, o_data, o_fire_N, o_count, o_afull, o_err
  );
endinterface

// File: rtl/sfifo_n_cache.sv
// sfifo_n_cache: DEPTH-entry, WIDTH-bit synchronous FIFO between the cache
// request pipeline and the memory-side stage.
// Ports:
//   clk  - single clock, all state changes on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - sfifo_n_cache_if.slave: push (i_drive/i_data/o_free),
//          pop (o_driveNext/o_data/i_freeNext), i_flush, and status
//          (o_fire_N, o_count, o_afull, o_err).
// Full and empty are strict: no bypass when full, no fall-through when empty.
// Handshake status is decoded from the count register only, so no output
// depends combinationally on i_drive or i_freeNext.
module sfifo_n_cache #(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 32,
  parameter int AFULL_TH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  sfifo_n_cache_if.slave        bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] fire_q, fire_d;
  logic             err_q, err_d;

  logic push;
  logic pop;
  logic full;
  logic empty;

  // Wrap at DEPTH-1 explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign bus.o_free      = !full;
  assign bus.o_driveNext = !empty;
  assign bus.o_afull     = (count_q >= CW'(AFULL_TH));
  assign bus.o_count     = count_q;
  assign bus.o_fire_N    = fire_q;
  assign bus.o_err       = err_q;
  assign bus.o_data      = mem_q[rptr_q];

  // Flush dominates both sides of the handshake.
  assign push = bus.i_drive    && !full  && !bus.i_flush;
  assign pop  = bus.i_freeNext && !empty && !bus.i_flush;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    fire_d  = '0;
    err_d   = err_q;

    if (bus.i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (push) begin
        wptr_d         = ptr_inc(wptr_q);
        fire_d[wptr_q] = 1'b1;
      end
      if (pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // A refused push (full) is an overflow; sticky until flush/reset.
      if (bus.i_drive && full) begin
        err_d = 1'b1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      fire_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      fire_q  <= fire_d;
      err_q   <= err_d;
    end
  end

  // NOTE: storage is reset as well so o_data reads a defined zero after
  // reset; flush deliberately leaves the contents untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wptr_q] <= bus.i_data;
    end
  end
endmodule

// File: tb/tb_sfifo_n_cache.sv
module tb_sfifo_n_cache;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sfifo_n_cache_if #(.DEPTH(4), .WIDTH(32)) b4 ();
  sfifo_n_cache_if #(.DEPTH(3), .WIDTH(32)) b3 ();

  sfifo_n_cache #(.DEPTH(4), .WIDTH(32), .AFULL_TH(3)) dut4 (
    .clk(clk), .rst(rst), .bus(b4)
  );
  sfifo_n_cache #(.DEPTH(3), .WIDTH(32), .AFULL_TH(2)) dut3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b4.i_drive = 0; b4.i_data = '0; b4.i_freeNext = 0; b4.i_flush = 0;
    b3.i_drive = 0; b3.i_data = '0; b3.i_freeNext = 0; b3.i_flush = 0;
    step();
    step();
    checks++;
    if ({b4.o_free, b4.o_driveNext, b4.o_afull, b4.o_err} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags4 got=%b exp=1000",
               {b4.o_free, b4.o_driveNext, b4.o_afull, b4.o_err});
    end
    checks++;
    if (b4.o_count !== 3'd0 || b4.o_fire_N !== 4'd0 || b4.o_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_state4 count=%0d fire=%b data=%h exp 0/0000/0",
               b4.o_count, b4.o_fire_N, b4.o_data);
    end
    checks++;
    if ({b3.o_free, b3.o_driveNext, b3.o_count, b3.o_fire_N} !== {2'b10, 2'd0, 3'd0}) begin
      failures++;
      $display("FAIL reset_state3 free=%b dn=%b count=%0d fire=%b",
               b3.o_free, b3.o_driveNext, b3.o_count, b3.o_fire_N);
    end
    rst = 1'b0;
  endtask

  // Push A1..A4 back to back, then one overflowing push.
  task automatic test_fill();
    logic [31:0] a [4];
    a = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    for (int i = 0; i < 4; i++) begin
      b4.i_drive = 1'b1;
      b4.i_data  = a[i];
      step();
      checks++;
      if (b4.o_fire_N !== 4'(1 << i)) begin
        failures++;
        $display("FAIL fill_fire[%0d] got=%b exp=%b", i, b4.o_fire_N, 4'(1 << i));
      end
      checks++;
      if (b4.o_count !== 3'(i + 1) || b4.o_free !== (i < 3) || b4.o_afull !== (i >= 2)) begin
        failures++;
        $display("FAIL fill_status[%0d] count=%0d free=%b afull=%b exp %0d/%b/%b",
                 i, b4.o_count, b4.o_free, b4.o_afull, i + 1, i < 3, i >= 2);
      end
      checks++;
      if (b4.o_data !== 32'hA1 || b4.o_driveNext !== 1'b1) begin
        failures++;
        $display("FAIL fill_head[%0d] data=%h dn=%b exp A1/1", i, b4.o_data, b4.o_driveNext);
      end
    end
    b4.i_data = 32'hBAD;
    step();
    checks++;
    if (b4.o_err !== 1'b1 || b4.o_count !== 3'd4 || b4.o_fire_N !== 4'd0) begin
      failures++;
      $display("FAIL overflow err=%b count=%0d fire=%b exp 1/4/0000",
               b4.o_err, b4.o_count, b4.o_fire_N);
    end
    b4.i_drive = 1'b0;
  endtask

  // Full: pop happens, simultaneous push refused; then drain in order.
  task automatic test_full_push_pop();
    logic [31:0] e [3];
    e = '{32'hA2, 32'hA3, 32'hA4};
    b4.i_drive = 1'b1; b4.i_data = 32'hBB; b4.i_freeNext = 1'b1;
    step();
    checks++;
    if (b4.o_count !== 3'd3 || b4.o_err !== 1'b1 || b4.o_fire_N !== 4'd0) begin
      failures++;
      $display("FAIL full_pp count=%0d err=%b fire=%b exp 3/1/0000",
               b4.o_count, b4.o_err, b4.o_fire_N);
    end
    b4.i_drive = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b4.o_data !== e[i]) begin
        failures++;
        $display("FAIL drain[%0d] got=%h exp=%h", i, b4.o_data, e[i]);
      end
      step();
    end
    b4.i_freeNext = 1'b0;
    checks++;
    if (b4.o_count !== 3'd0 || b4.o_driveNext !== 1'b0 || b4.o_err !== 1'b1) begin
      failures++;
      $display("FAIL drain_end count=%0d dn=%b err=%b exp 0/0/1",
               b4.o_count, b4.o_driveNext, b4.o_err);
    end
  endtask

  // DEPTH=3: push 7 words with consumer always ready.
  task automatic test_wrap();
    b3.i_freeNext = 1'b1;
    for (int i = 0; i < 7; i++) begin
      b3.i_drive = 1'b1;
      b3.i_data  = 32'h300 + 32'(i);
      step();
      checks++;
      if (b3.o_fire_N !== 3'(1 << (i % 3)) || b3.o_data !== 32'h300 + 32'(i) ||
          b3.o_count !== 2'd1) begin
        failures++;
        $display("FAIL wrap[%0d] fire=%b data=%h count=%0d exp %b/%h/1",
                 i, b3.o_fire_N, b3.o_data, b3.o_count, 3'(1 << (i % 3)), 32'h300 + 32'(i));
      end
    end
    b3.i_drive = 1'b0;
    step();
    checks++;
    if (b3.o_count !== 2'd0 || b3.o_driveNext !== 1'b0 || b3.o_fire_N !== 3'd0) begin
      failures++;
      $display("FAIL wrap_end count=%0d dn=%b fire=%b exp 0/0/000",
               b3.o_count, b3.o_driveNext, b3.o_fire_N);
    end
    b3.i_freeNext = 1'b0;
  endtask

  // Hold count at 2 while pushing and popping every cycle.
  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      b4.i_drive = 1'b1;
      b4.i_data  = 32'h500 + 32'(i);
      step();
    end
    b4.i_freeNext = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b4.i_data = 32'h500 + 32'(i + 2);
      checks++;
      if (b4.o_data !== 32'h500 + 32'(i)) begin
        failures++;
        $display("FAIL stream_data[%0d] got=%h exp=%h", i, b4.o_data, 32'h500 + 32'(i));
      end
      step();
      checks++;
      if (b4.o_count !== 3'd2) begin
        failures++;
        $display("FAIL stream_count[%0d] got=%0d exp=2", i, b4.o_count);
      end
    end
    b4.i_freeNext = 1'b0;
    b4.i_data = 32'h50C;
    step();
    b4.i_drive = 1'b0;
    checks++;
    if (b4.o_count !== 3'd3 || b4.o_afull !== 1'b1) begin
      failures++;
      $display("FAIL stream_end count=%0d afull=%b exp 3/1", b4.o_count, b4.o_afull);
    end
  endtask

  // Flush at count 3 with a push in the same cycle; err was left set earlier.
  task automatic test_flush();
    checks++;
    if (b4.o_err !== 1'b1) begin
      failures++;
      $display("FAIL flush_pre_err got=%b exp=1", b4.o_err);
    end
    b4.i_flush = 1'b1; b4.i_drive = 1'b1; b4.i_data = 32'hDEAD;
    step();
    b4.i_flush = 1'b0; b4.i_drive = 1'b0;
    checks++;
    if (b4.o_count !== 3'd0 || b4.o_driveNext !== 1'b0 || b4.o_err !== 1'b0 ||
        b4.o_fire_N !== 4'd0 || b4.o_free !== 1'b1) begin
      failures++;
      $display("FAIL flush count=%0d dn=%b err=%b fire=%b free=%b exp 0/0/0/0000/1",
               b4.o_count, b4.o_driveNext, b4.o_err, b4.o_fire_N, b4.o_free);
    end
    step();
    checks++;
    if (b4.o_driveNext !== 1'b0) begin
      failures++;
      $display("FAIL flush_dropped dn=%b exp=0", b4.o_driveNext);
    end
    b4.i_drive = 1'b1; b4.i_data = 32'hC1;
    step();
    b4.i_drive = 1'b0;
    checks++;
    if (b4.o_data !== 32'hC1 || b4.o_count !== 3'd1 || b4.o_fire_N !== 4'b0001) begin
      failures++;
      $display("FAIL post_flush data=%h count=%0d fire=%b exp C1/1/0001",
               b4.o_data, b4.o_count, b4.o_fire_N);
    end
  endtask

  // Reset mid-cycle with count 2; outputs must clear before any edge.
  task automatic test_async_reset();
    b4.i_drive = 1'b1; b4.i_data = 32'hC2;
    step();
    b4.i_drive = 1'b0;
    checks++;
    if (b4.o_count !== 3'd2) begin
      failures++;
      $display("FAIL areset_pre count=%0d exp=2", b4.o_count);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({b4.o_free, b4.o_driveNext, b4.o_afull, b4.o_err} !== 4'b1000 ||
        b4.o_count !== 3'd0 || b4.o_fire_N !== 4'd0 || b4.o_data !== 32'd0) begin
      failures++;
      $display("FAIL areset free=%b dn=%b afull=%b err=%b count=%0d fire=%b data=%h exp 1/0/0/0/0/0000/0",
               b4.o_free, b4.o_driveNext, b4.o_afull, b4.o_err, b4.o_count, b4.o_fire_N, b4.o_data);
    end
    step();
    rst = 1'b0;
    b4.i_drive = 1'b1; b4.i_data = 32'hD1;
    step();
    b4.i_drive = 1'b0;
    checks++;
    if (b4.o_data !== 32'hD1 || b4.o_count !== 3'd1) begin
      failures++;
      $display("FAIL after_reset_push data=%h count=%0d exp D1/1", b4.o_data, b4.o_count);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fill();
    test_full_push_pop();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case anything above stalls.
  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end
endmodule
